// File: rtl/clint_pkg.sv
// clint_pkg: shared definitions for the machine timer / software-interrupt block.
//   - reg_off_e     : word offsets (addr[4:2]) of the eight bus-visible registers
//   - MTIMECMP_RST  : reset value of the 64-bit compare register
//   - CTRL_EN_BIT   : bit index of the count-enable flag in CTRL
//   - be_merge()    : byte-enable merge of write data into an existing word
package clint_pkg;

  typedef enum logic [2:0] {
    OFF_MSIP        = 3'd0,
    OFF_CTRL        = 3'd1,
    OFF_MTIME_LO    = 3'd2,
    OFF_MTIME_HI    = 3'd3,
    OFF_MTIMECMP_LO = 3'd4,
    OFF_MTIMECMP_HI = 3'd5,
    OFF_PRESCALE    = 3'd6,
    OFF_RSVD        = 3'd7
  } reg_off_e;

  localparam logic [63:0] MTIMECMP_RST = '1;
  localparam int unsigned CTRL_EN_BIT  = 0;

  // Replace each byte of old_v whose enable is set with the matching byte of new_v.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: divides clk into mtime ticks.
//   clk, reset   : core clock, asynchronous active-high reset
//   i_enable     : count enable (CTRL[0]); when low the counter sits at 0
//   i_load       : load a new divisor; also restarts the count at 0
//   i_div        : divisor value to load
//   o_div        : current divisor (for bus readback)
//   o_tick       : one-cycle strobe every (divisor+1) enabled cycles
module clint_prescaler #(
  parameter int unsigned PRESCALE_W   = 16,
  parameter int unsigned PRESCALE_RST = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic                  i_load,
  input  logic [PRESCALE_W-1:0] i_div,
  output logic [PRESCALE_W-1:0] o_div,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_div;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  w_tick;

  assign w_tick = i_enable && (r_pcnt == r_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= PRESCALE_W'(PRESCALE_RST);
    end else if (i_load) begin
      r_div <= i_div;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt <= '0;
    end else if (i_load || !i_enable || w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PRESCALE_W'(1);
    end
  end

  assign o_div  = r_div;
  assign o_tick = w_tick;

endmodule

// File: rtl/clint_timer.sv
// clint_timer: memory-mapped machine timer and software-interrupt source on the
// core data bus, sharing the RAM data-port protocol (byte write enables,
// read-first registered read data, rdata holds while en is low).
//   clk, reset : core clock, asynchronous active-high reset
//   en         : bus cycle enable; rdata holds when low
//   sel        : address decode hit; only meaningful with en=1
//   we[3:0]    : byte write enables
//   addr[4:0]  : byte offset, word select in addr[4:2]
//   wdata      : write data
//   rdata      : read data, valid the cycle after the request
//   timer_int  : registered (mtime >= mtimecmp)
//   sw_int     : registered msip[0]
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned PRESCALE_W   = 16,
  parameter int unsigned PRESCALE_RST = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        sel,
  input  logic [3:0]  we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        timer_int,
  output logic        sw_int
);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic        r_ctrl_en;
  logic [31:0] r_shadow;

  logic                  w_access;
  logic                  w_write;
  reg_off_e              w_off;
  logic [31:0]           w_cur;
  logic [31:0]           w_rd_val;
  logic [31:0]           w_wr_word;
  logic                  w_load_div;
  logic                  w_tick;
  logic [PRESCALE_W-1:0] w_div;
  logic                  w_unused_addr;

  assign w_access      = en && sel;
  assign w_write       = w_access && (|we);
  assign w_off         = reg_off_e'(addr[4:2]);
  assign w_unused_addr = ^addr[1:0];

  // Live value of the addressed register; the write path merges into this.
  always_comb begin
    w_cur = '0;
    case (w_off)
      OFF_MSIP:        w_cur = {31'b0, r_msip};
      OFF_CTRL:        w_cur = {31'b0, r_ctrl_en};
      OFF_MTIME_LO:    w_cur = r_mtime[31:0];
      OFF_MTIME_HI:    w_cur = r_mtime[63:32];
      OFF_MTIMECMP_LO: w_cur = r_mtimecmp[31:0];
      OFF_MTIMECMP_HI: w_cur = r_mtimecmp[63:32];
      OFF_PRESCALE:    w_cur = 32'(w_div);
      OFF_RSVD:        w_cur = '0;
      default:         w_cur = '0;
    endcase
  end

  // Bus reads of MTIME_HI see the shadow captured by the last MTIME_LO read,
  // so a LO-then-HI sequence yields a coherent 64-bit sample.
  assign w_rd_val   = (w_off == OFF_MTIME_HI) ? r_shadow : w_cur;
  assign w_wr_word  = be_merge(w_cur, wdata, we);
  assign w_load_div = w_write && (w_off == OFF_PRESCALE);

  clint_prescaler #(
    .PRESCALE_W   (PRESCALE_W),
    .PRESCALE_RST (PRESCALE_RST)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .i_enable (r_ctrl_en),
    .i_load   (w_load_div),
    .i_div    (PRESCALE_W'(w_wr_word)),
    .o_div    (w_div),
    .o_tick   (w_tick)
  );

  // Control/compare registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msip     <= 1'b0;
      r_ctrl_en  <= 1'b0;
      r_mtimecmp <= MTIMECMP_RST;
    end else if (w_write) begin
      case (w_off)
        OFF_MSIP:        r_msip             <= w_wr_word[0];
        OFF_CTRL:        r_ctrl_en          <= w_wr_word[CTRL_EN_BIT];
        OFF_MTIMECMP_LO: r_mtimecmp[31:0]  <= w_wr_word;
        OFF_MTIMECMP_HI: r_mtimecmp[63:32] <= w_wr_word;
        default: ;
      endcase
    end
  end

  // mtime: a bus write to either half wins over the tick and suppresses the
  // increment entirely for that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mtime <= '0;
    end else if (w_write && (w_off == OFF_MTIME_LO)) begin
      r_mtime[31:0] <= w_wr_word;
    end else if (w_write && (w_off == OFF_MTIME_HI)) begin
      r_mtime[63:32] <= w_wr_word;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
    end else if (w_access && (w_off == OFF_MTIME_LO)) begin
      r_shadow <= r_mtime[63:32];
    end
  end

  // Read-first data return: every access samples the pre-write value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= sel ? w_rd_val : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_int <= 1'b0;
      sw_int    <= 1'b0;
    end else begin
      timer_int <= (r_mtime >= r_mtimecmp);
      sw_int    <= r_msip;
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: directed and randomized bus traffic against clint_timer,
// compared every cycle with a register-level reference model.
module tb_clint_timer;

  localparam int unsigned PW = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        sel;
  logic [3:0]  we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        timer_int;
  logic        sw_int;

  clint_timer #(
    .PRESCALE_W   (PW),
    .PRESCALE_RST (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sel       (sel),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .timer_int (timer_int),
    .sw_int    (sw_int)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus the observable outputs.
  logic [63:0]   m_time, m_cmp;
  logic          m_msip, m_ctrl;
  logic [PW-1:0] m_div, m_pcnt;
  logic [31:0]   m_shadow, m_rdata;
  logic          m_tint, m_sint;

  task automatic model_reset();
    m_time   = 64'd0;
    m_cmp    = {64{1'b1}};
    m_msip   = 1'b0;
    m_ctrl   = 1'b0;
    m_div    = '0;
    m_pcnt   = '0;
    m_shadow = 32'd0;
    m_rdata  = 32'd0;
    m_tint   = 1'b0;
    m_sint   = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic s, input logic [3:0] w,
                            input logic [4:0] a, input logic [31:0] d);
    logic        acc, wr, tick;
    int unsigned off;
    logic [31:0] regs [8];
    logic [31:0] rv, nv;
    acc = e && s;
    wr  = acc && (w != 4'h0);
    off = a[4:2];
    regs[0] = {31'b0, m_msip};
    regs[1] = {31'b0, m_ctrl};
    regs[2] = m_time[31:0];
    regs[3] = m_time[63:32];
    regs[4] = m_cmp[31:0];
    regs[5] = m_cmp[63:32];
    regs[6] = 32'(m_div);
    regs[7] = 32'd0;
    tick = m_ctrl && (m_pcnt == m_div);
    rv   = (off == 3) ? m_shadow : regs[off];
    nv   = regs[off];
    for (int i = 0; i < 4; i++) if (w[i]) nv[8*i +: 8] = d[8*i +: 8];
    m_tint = (m_time >= m_cmp);
    m_sint = m_msip;
    if (e) m_rdata = s ? rv : 32'd0;
    if (acc && off == 2) m_shadow = m_time[63:32];
    if ((wr && off == 6) || !m_ctrl || tick) m_pcnt = '0;
    else m_pcnt = m_pcnt + 1'b1;
    if (tick && !(wr && (off == 2 || off == 3))) m_time = m_time + 64'd1;
    if (wr) begin
      case (off)
        0: m_msip = nv[0];
        1: m_ctrl = nv[0];
        2: m_time[31:0]  = nv;
        3: m_time[63:32] = nv;
        4: m_cmp[31:0]   = nv;
        5: m_cmp[63:32]  = nv;
        6: m_div = nv[PW-1:0];
        default: ;
      endcase
    end
  endtask

  // One bus cycle: drive, advance model, clock, compare all outputs.
  task automatic cycle(input logic e, input logic s, input logic [3:0] w,
                       input logic [4:0] a, input logic [31:0] d);
    en = e; sel = s; we = w; addr = a; wdata = d;
    model_step(e, s, w, a, d);
    @(posedge clk);
    #1;
    check("rdata", rdata, m_rdata);
    check("timer_int", timer_int, m_tint);
    check("sw_int", sw_int, m_sint);
  endtask

  task automatic wr(input int unsigned off, input logic [31:0] d);
    cycle(1'b1, 1'b1, 4'hF, 5'(off << 2), d);
  endtask

  task automatic rd(input int unsigned off);
    cycle(1'b1, 1'b1, 4'h0, 5'(off << 2), 32'd0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 4'h0, 5'd0, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b0; sel = 1'b0; we = 4'h0; addr = 5'd0; wdata = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_timer_int", timer_int, 1'b0);
    check("rst_sw_int", sw_int, 1'b0);
    reset = 1'b0;

    // Reset values of every offset.
    for (int unsigned o = 0; o < 8; o++) begin
      rd(o);
      check("rst_read", rdata, (o == 4 || o == 5) ? 32'hFFFF_FFFF : 32'd0);
    end

    // rdata holds while en is low.
    rd(4);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("hold_rdata", rdata, 32'hFFFF_FFFF);
    end
    // en=1, sel=0 clears rdata.
    cycle(1'b1, 1'b0, 4'h0, 5'd16, 32'd0);
    check("nosel_rdata", rdata, 32'd0);

    // Prescaler divide-by-4 over a 40-cycle window.
    wr(6, 32'd3);
    wr(1, 32'd1);
    repeat (40) idle();
    rd(2);
    check("presc_window", (rdata >= 32'd9 && rdata <= 32'd11), 1'b1);
    wr(1, 32'd0);

    // Carry into MTIME_HI and shadow coherency.
    wr(6, 32'd0);
    wr(3, 32'd0);
    wr(2, 32'hFFFF_FFFE);
    wr(1, 32'd1);
    idle();
    wr(1, 32'd0);
    rd(2);
    check("carry_lo", rdata, 32'd0);
    wr(3, 32'd5);
    rd(3);
    check("shadow_hi", rdata, 32'd1);
    rd(2);
    check("lo_after_hi_write", rdata, 32'd0);
    rd(3);
    check("shadow_hi_new", rdata, 32'd5);

    // 64-bit wrap from all-ones.
    wr(3, 32'hFFFF_FFFF);
    wr(2, 32'hFFFF_FFFF);
    wr(1, 32'd1);
    rd(2);
    check("wrap_lo_pre", rdata, 32'hFFFF_FFFF);
    rd(3);
    check("wrap_hi_pre", rdata, 32'hFFFF_FFFF);
    rd(2);
    check("wrap_lo_post", rdata, 32'd1);
    rd(3);
    check("wrap_hi_post", rdata, 32'd0);
    wr(1, 32'd0);

    // timer_int timing against mtimecmp = 20.
    wr(5, 32'd0);
    wr(4, 32'd20);
    wr(3, 32'd0);
    wr(2, 32'd0);
    wr(1, 32'd1);
    for (int k = 1; k <= 25; k++) begin
      idle();
      check("tint_rise", timer_int, (k >= 21));
    end
    wr(5, 32'd1);
    idle();
    check("tint_clear", timer_int, 1'b0);
    wr(1, 32'd0);

    // sw_int with partial byte enables.
    cycle(1'b1, 1'b1, 4'b0001, 5'd0, 32'd1);
    idle();
    check("sw_set", sw_int, 1'b1);
    cycle(1'b1, 1'b1, 4'b0010, 5'd0, 32'd0);
    idle();
    check("sw_keep", sw_int, 1'b1);
    wr(0, 32'd0);
    idle();
    check("sw_clear", sw_int, 1'b0);

    // Randomized traffic, values biased so compares and ticks actually happen.
    for (int i = 0; i < 3000; i++) begin
      logic        e, s;
      logic [3:0]  w;
      logic [2:0]  o;
      logic [31:0] d;
      e = ($urandom_range(0, 9) < 8);
      s = ($urandom_range(0, 9) < 8);
      w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      o = 3'($urandom);
      case (o)
        3'd2, 3'd4: d = $urandom_range(0, 300);
        3'd3, 3'd5: d = $urandom_range(0, 1);
        3'd6:       d = $urandom_range(0, 3);
        default:    d = $urandom;
      endcase
      if ($urandom_range(0, 49) == 0) d = $urandom;
      cycle(e, s, w, {o, 2'b00} | 5'($urandom_range(0, 3)), d);
    end

    // Asynchronous reset mid-count with timer_int high and rdata non-zero.
    wr(4, 32'd0);
    wr(5, 32'd0);
    wr(3, 32'd0);
    wr(2, 32'd7);
    wr(6, 32'd0);
    wr(1, 32'd1);
    idle();
    idle();
    rd(2);
    check("pre_rst_tint", timer_int, 1'b1);
    check("pre_rst_rdata_nz", (rdata != 32'd0), 1'b1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_rdata", rdata, 32'd0);
    check("async_rst_tint", timer_int, 1'b0);
    check("async_rst_sw", sw_int, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd(2);
    check("post_rst_mtime", rdata, 32'd0);
    rd(4);
    check("post_rst_cmp", rdata, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
